// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared constants and state encoding for the 4-way round-robin arbiter
package mux4_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MAX_BEATS = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4: first requester found searching last+1, last+2, ... modulo 4
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               found,
  output logic [1:0]         idx
);
  logic [1:0] k;
  // Walk from farthest to nearest so the nearest hit overwrites earlier ones
  always_comb begin
    found = 1'b0;
    idx = 2'd0;
    k = 2'd0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = last + 2'(i);
      if (req[k]) begin
        found = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/mux_4_1.sv
// mux_4_1: single-bit 4:1 multiplexer primitive
module mux_4_1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);
  assign y = d[s];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: packet-granular round-robin arbiter steering 4 valid/ready ports onto one
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int CNT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*WIDTH-1:0]   in_data,
  input  logic [NUM_REQ-1:0]         in_valid,
  input  logic [NUM_REQ-1:0]         in_last,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [1:0]                 sel,
  output logic                       busy
);
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [1:0] sel_n, last, last_n, idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic found, xfer, rel;

  rr_pick4 u_pick (.req(in_valid), .last(last), .found(found), .idx(idx));

  assign busy = state == ST_BUSY;
  assign out_valid = busy & in_valid[sel];
  assign out_last = busy & in_last[sel];
  assign in_ready = busy ? (NUM_REQ'(out_ready) << sel) : '0;
  assign xfer = out_valid & out_ready;
  // The transfer in flight is beat cnt+1, so the cap is hit when cnt reaches MAX_BEATS-1
  assign rel = xfer & (in_last[sel] | cnt == CNT_W'(MAX_BEATS - 1));

  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    mux_4_1 u_mux (
      .d({in_data[3*WIDTH+b], in_data[2*WIDTH+b], in_data[WIDTH+b], in_data[b]}),
      .s(sel),
      .y(out_data[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      sel <= 2'd0;
      last <= 2'd3;
      cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel <= sel_n;
      last <= last_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n = sel;
    last_n = last;
    cnt_n = cnt;
    if (!busy) begin
      if (found) begin
        state_n = ST_BUSY;
        grant_n = NUM_REQ'(1) << idx;
        sel_n = idx;
        cnt_n = '0;
      end
    end else if (rel) begin
      state_n = ST_IDLE;
      grant_n = '0;
      last_n = sel;
      cnt_n = '0;
    end else if (xfer) begin
      cnt_n = (cnt == CNT_W'(MAX_BEATS)) ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready channel among 4 requesters by sequencing the select of a 4:1 datapath mux.
- A grant is held for a whole packet (until the last beat) or until MAX_BEATS beats, then priority rotates.
- Sits between 4 producer ports and a single consumer, for example a shared bus or writeback port.

Parameters:
- WIDTH, 8, data width per requester.
- MAX_BEATS, 16, maximum beats per grant before forced release (>=1).
- CNT_W, 5, beat-counter width; must hold MAX_BEATS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  4*WIDTH  requester data; requester k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  4  per-requester valid.
- in_last  in  4  per-requester end-of-packet flag.
- in_ready  out  4  per-requester ready.
- out_data  out  WIDTH  muxed data.
- out_valid  out  1  muxed valid.
- out_last  out  1  muxed last.
- out_ready  in  1  consumer ready.
- grant  out  4  one-hot current owner; 0 when idle.
- sel  out  2  registered mux select (binary of grant).
- busy  out  1  high in BUSY state.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - state=IDLE, grant=0, sel=0, busy=0, beat count=0, priority pointer last=3 (requester 0 highest after reset).
  - All outputs go low: in_ready=0, out_valid=0, out_last=0.
  - out_data is a don't-care but must be driven.
- FSM IDLE:
  - If any in_valid is high, pick the first k with in_valid[k] set, searching last+1, last+2, ... modulo 4.
  - Register grant=onehot(k) and sel=k, clear the beat count, go to BUSY.
  - Arbitration latency is one cycle: no data transfers in IDLE, and in_ready=0.
- FSM BUSY, with owner g=sel:
  - out_data=in_data[g], out_valid=in_valid[g], out_last=in_last[g]; all combinational through the registered select.
  - in_ready[g]=out_ready; in_ready of all other requesters is 0.
  - A transfer occurs on out_valid & out_ready; each transfer increments the beat count.
  - Release when a transfer carries in_last[g], or when the transfer is beat number MAX_BEATS.
  - On release: last<=g, grant<=0, go to IDLE. The next grant comes one cycle later, giving 1 idle bubble between packets.
  - If owner valid drops mid-packet, hold the grant and wait indefinitely; no timeout.
  - Requests from other ports while BUSY are ignored and do not preempt.
- Priority:
  - last updates only on release.
  - A requester that is the sole requester may be re-granted immediately (after the IDLE cycle).
- Beat counter: saturates at MAX_BEATS, and release forces it to clear. MAX_BEATS=1 means every beat rotates.
- Reset mid-packet: abort without completing the packet; the next cycle is IDLE with last=3. The upstream owner sees in_ready drop.
- Invariants: grant is one-hot or zero; at most one in_ready bit is high; busy == (grant != 0).

Decomposition:
- Shared package/header:
  - NUM_REQ=4.
  - State encoding: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - Default WIDTH and MAX_BEATS constants.
- Sub-module rr_pick4 (combinational): inputs req[3:0] and last[1:0]; outputs found and idx[1:0]. This keeps the rotate/priority-encode logic separately testable.
- Output data mux: the existing mux_4_1 primitive replicated WIDTH times via generate, select = sel.

Test Plan:
- Reset then single request:
  - Stimulus: in_valid=0001, 3-beat packet, out_ready=1.
  - Required: grant=0001 one cycle after valid; beats 1..3 pass on consecutive cycles; grant=0 the cycle after the last beat.
- Round-robin fairness:
  - Stimulus: all four valid continuously, 1-beat packets (in_last=1111).
  - Required: grant sequence 0001,0010,0100,1000,0001 with one IDLE cycle between grants.
- Back-pressure and owner stall:
  - Stimulus: owner 2 mid-packet; out_ready=0 for 3 cycles, then in_valid[2]=0 for 2 cycles.
  - Required: grant stays 0100, no beat counted, out_data stable, in_ready=0000 while out_ready=0.
- Forced release:
  - Stimulus: MAX_BEATS=4, requester 1 sends 10 beats with in_last=0, requester 3 also valid.
  - Required: release after beat 4, next grant=1000, requester 1 resumes only after requester 3 finishes.
- Reset mid-packet:
  - Stimulus: assert rst during beat 2 of owner 3's packet, with requesters 0 and 3 both valid.
  - Required: the cycle after rst, all outputs are 0; after rst deasserts, the first grant is 0001.
- Non-preemption:
  - Stimulus: owner 0 in a 5-beat packet; requester 1 asserts valid at beat 2.
  - Required: in_ready[1]=0 throughout, and grant=0010 only after owner 0's last beat plus one IDLE cycle.
